mem_dual_xor_acc: RTL and testbench



---
 rtl/mem_dual_xor_acc_pkg.sv | 14 +
 rtl/mem_dual_xor_acc_rmw.sv | 57 +++++
 rtl/mem_dual_xor_acc.sv | 133 +++++++++++++
 tb/tb_mem_dual_xor_acc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dual_xor_acc_pkg.sv
// Shared definitions for the dual-port XOR accumulator: FSM encoding and the
// address-width derivation used by every file of the block.
package mem_dual_xor_acc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ACC   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic int mem_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_dual_xor_acc_rmw.sv
// S1 read-modify-write stage: holds the accepted item while the RAM read
// returns, forwards the previous write on a back-to-back same-address pair.
module mem_xor_rmw_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             acc_valid,
  input  logic [AW-1:0]    acc_addr,
  input  logic [WIDTH-1:0] acc_data,
  input  logic [WIDTH-1:0] mem_q,
  output logic             wr_valid,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  logic             s1_valid_q, s1_valid_d;
  logic [AW-1:0]    s1_addr_q, s1_addr_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             w_valid_q, w_valid_d;
  logic [AW-1:0]    w_addr_q, w_addr_d;
  logic [WIDTH-1:0] w_data_q, w_data_d;
  logic [WIDTH-1:0] old_word;

  always_comb begin
    // The RAM returns pre-write data when the previous item hit the same word.
    old_word  = (w_valid_q && (w_addr_q == s1_addr_q)) ? w_data_q : mem_q;
    wr_valid  = s1_valid_q;
    wr_addr   = s1_addr_q;
    wr_data   = old_word ^ s1_data_q;
    s1_valid_d = acc_valid;
    s1_addr_d  = acc_valid ? acc_addr : s1_addr_q;
    s1_data_d  = acc_valid ? acc_data : s1_data_q;
    w_valid_d  = s1_valid_q;
    w_addr_d   = s1_addr_q;
    w_data_d   = wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      w_valid_q  <= w_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    s1_addr_q <= s1_addr_d;
    s1_data_q <= s1_data_d;
    w_addr_q  <= w_addr_d;
    w_data_q  <= w_data_d;
  end

endmodule

// File: rtl/mem_dual_xor_acc.sv
// Dual-port RAM controller: bulk clear, streamed XOR accumulation
// (mem[addr] ^= data at one item per cycle) and single-word readout.
module mem_dual_xor_acc
  import mem_dual_xor_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW   = mem_aw(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_clear,
  input  logic             start_acc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_address_0,
  output logic [WIDTH-1:0] mem_data_0,
  output logic             mem_wren_0,
  input  logic [WIDTH-1:0] mem_q_0,
  output logic [AW-1:0]    mem_address_1,
  output logic [WIDTH-1:0] mem_data_1,
  output logic             mem_wren_1
);

  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH / 2 - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [AW-1:0]    clr_base;
  logic             acc_valid;
  logic             wr_valid;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  mem_xor_rmw_stage #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_rmw (
    .clock     (clock),
    .reset     (reset),
    .acc_valid (acc_valid),
    .acc_addr  (in_addr),
    .acc_data  (in_data),
    .mem_q     (mem_q_0),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    rd_valid_d    = 1'b0;
    in_ready      = 1'b0;
    acc_valid     = 1'b0;
    clr_base      = cnt_q << 1;
    mem_address_0 = rd_addr;
    mem_data_0    = '0;
    mem_wren_0    = 1'b0;
    mem_address_1 = wr_addr;
    mem_data_1    = wr_data;
    mem_wren_1    = wr_valid;
    case (state_q)
      ST_IDLE: begin
        if (start_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (start_acc) begin
          state_d = ST_ACC;
        end else if (rd_req) begin
          rd_valid_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        // Even word on port 0, odd word on port 1, so addresses never collide.
        mem_address_0 = clr_base;
        mem_wren_0    = 1'b1;
        mem_address_1 = clr_base | AW'(1);
        mem_data_1    = '0;
        mem_wren_1    = 1'b1;
        if (cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_ACC: begin
        in_ready      = 1'b1;
        mem_address_0 = in_addr;
        acc_valid     = in_valid;
        if (in_valid && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_q_0 : '0;

endmodule

// File: tb/tb_mem_dual_xor_acc.sv
// Bench for mem_dual_xor_acc with DEPTH=8 and a behavioural dual-port RAM
// (registered read, old data on cross-port same-address access).
module tb_mem_dual_xor_acc;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clock;
  logic             reset;
  logic             start_clear, start_acc;
  logic             in_valid, in_ready, in_last;
  logic [AW-1:0]    in_addr;
  logic [WIDTH-1:0] in_data;
  logic             rd_req, rd_valid;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy, done;
  logic [AW-1:0]    mem_address_0, mem_address_1;
  logic [WIDTH-1:0] mem_data_0, mem_data_1, mem_q_0;
  logic             mem_wren_0, mem_wren_1;

  mem_dual_xor_acc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_clear   (start_clear),
    .start_acc     (start_acc),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_last       (in_last),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .mem_address_0 (mem_address_0),
    .mem_data_0    (mem_data_0),
    .mem_wren_0    (mem_wren_0),
    .mem_q_0       (mem_q_0),
    .mem_address_1 (mem_address_1),
    .mem_data_1    (mem_data_1),
    .mem_wren_1    (mem_wren_1)
  );

  // Dual-port RAM model with a bench-controlled preload.
  logic [WIDTH-1:0] ram [DEPTH];
  logic             ram_preload;
  logic [WIDTH-1:0] ram_preload_val;

  always @(posedge clock) begin
    if (ram_preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= ram_preload_val;
    end else begin
      if (mem_wren_0) ram[mem_address_0] <= mem_data_0;
      if (mem_wren_1) ram[mem_address_1] <= mem_data_1;
    end
    mem_q_0 <= ram[mem_address_0];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] exp_mem [DEPTH];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Readout scoreboard and port-collision check, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset && rd_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, expected no readout", rd_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = sb_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
    if (!reset && mem_wren_0 && mem_wren_1 && (mem_address_0 == mem_address_1)) begin
      total++;
      bad++;
      $display("FAIL port_collision: both ports write address %0d", mem_address_0);
    end
  end

  task automatic read_word(input int a, input logic [WIDTH-1:0] expv);
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    sb_q.push_back(expv);
    tick();
    rd_req = 1'b0;
  endtask

  typedef struct {
    logic [3:0]       addr;
    logic [WIDTH-1:0] data;
    bit               valid;
    bit               last;
  } item_t;

  typedef struct {
    int               addr;
    logic [WIDTH-1:0] val;
  } word_t;

  item_t items [$];
  word_t words [$];

  task automatic run_stream(input int first, output int next);
    int  k;
    logic [AW-1:0] a;
    start_acc = 1'b1;
    tick();
    start_acc = 1'b0;
    k = first;
    forever begin
      a        = items[k].addr[AW-1:0];
      in_valid = items[k].valid;
      in_addr  = a;
      in_data  = items[k].data;
      in_last  = items[k].last;
      chk($sformatf("in_ready_acc[%0d]", k), {31'd0, in_ready}, 32'd1);
      tick();
      if (items[k].valid) exp_mem[a] = exp_mem[a] ^ items[k].data;
      if (items[k].valid && items[k].last) break;
      k++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
    chk("drain_write", {31'd0, mem_wren_1}, 32'd1);
    chk("done_early", {31'd0, done}, 32'd0);
    tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_after_acc", {31'd0, busy}, 32'd0);
    tick();
    chk("done_clears", {31'd0, done}, 32'd0);
    next = k + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idx;
    reset = 1'b1; start_clear = 1'b0; start_acc = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0; in_last = 1'b0;
    rd_req = 1'b0; rd_addr = '0;
    ram_preload = 1'b1; ram_preload_val = 32'hFFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hFFFF_FFFF;

    // Stream table: single item, back-to-back hazard, gap hazard, interleave, wrap.
    items.push_back('{4'd3,  32'h0000_00A5, 1'b1, 1'b1});
    items.push_back('{4'd5,  32'h0000_000F, 1'b1, 1'b0});
    items.push_back('{4'd5,  32'h0000_00F0, 1'b1, 1'b0});
    items.push_back('{4'd5,  32'h0000_00FF, 1'b1, 1'b1});
    items.push_back('{4'd2,  32'h0000_0011, 1'b1, 1'b0});
    items.push_back('{4'd0,  32'hDEAD_BEEF, 1'b0, 1'b0});
    items.push_back('{4'd2,  32'h0000_0022, 1'b1, 1'b1});
    items.push_back('{4'd1,  32'h0000_0001, 1'b1, 1'b0});
    items.push_back('{4'd4,  32'h0000_0002, 1'b1, 1'b0});
    items.push_back('{4'd1,  32'h0000_0004, 1'b1, 1'b1});
    items.push_back('{4'd11, 32'h0000_005A, 1'b1, 1'b1});

    words.push_back('{3, 32'h0000_00A5});
    words.push_back('{5, 32'h0000_0000});
    words.push_back('{2, 32'h0000_0033});
    words.push_back('{1, 32'h0000_0005});
    words.push_back('{4, 32'h0000_0002});

    tick(); tick(); tick();
    ram_preload = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_wren", {30'd0, mem_wren_0, mem_wren_1}, 32'd0);
    reset = 1'b0;
    tick();

    // Clear with a simultaneous start_acc that must be dropped.
    start_clear = 1'b1; start_acc = 1'b1;
    tick();
    start_clear = 1'b0; start_acc = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    chk("clear_cycles", n, 32'd4);
    chk("clear_done", {31'd0, done}, 32'd1);
    tick();
    chk("clear_done_once", {31'd0, done}, 32'd0);
    chk("start_acc_dropped", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) read_word(i, 32'd0);
    tick();

    // First four streams, then spot-check hand-computed words.
    idx = 0;
    for (int s = 0; s < 4; s++) run_stream(idx, idx);
    foreach (words[w]) read_word(words[w].addr, words[w].val);
    tick();

    // Wrap: address 11 lands on word 3; every other word unchanged.
    run_stream(idx, idx);
    read_word(3, 32'h0000_00FF);
    for (int i = 0; i < DEPTH; i++) read_word(i, exp_mem[i]);
    tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    // Readout ignored while busy.
    start_acc = 1'b1;
    tick();
    start_acc = 1'b0;
    rd_req = 1'b1; rd_addr = 3'd0;
    tick();
    rd_req = 1'b0;
    chk("rd_ignored_busy", {31'd0, rd_valid}, 32'd0);

    // Reset with S1 holding a valid item.
    in_valid = 1'b1; in_addr = 3'd6; in_data = 32'h77; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_mid_wren1", {31'd0, mem_wren_1}, 32'd0);
    chk("rst_mid_wren0", {31'd0, mem_wren_0}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || mem_wren_1) n++;
      tick();
    end
    chk("rst_mid_no_done", n, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
